// File: rtl/decode_stage.sv
// RV32I decode stage: instruction decoder, 32x32 register file with
// write-first bypass, and the ID/EX register that feeds execute.
module decode_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    input  logic        stall,
    input  logic        flush,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    output logic [31:0] imm_new,
    output logic        alusrc,
    output logic        branch,
    output logic [3:0]  aluop,
    output logic        regwrite,
    output logic        memread,
    output logic        memwrite,
    output logic        memtoreg,
    output logic [4:0]  rd,
    output logic        ex_valid,
    output logic        illegal
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;

    localparam logic [6:0] OPC_R    = 7'b0110011;
    localparam logic [6:0] OPC_I    = 7'b0010011;
    localparam logic [6:0] OPC_LW   = 7'b0000011;
    localparam logic [6:0] OPC_SW   = 7'b0100011;
    localparam logic [6:0] OPC_BEQ  = 7'b1100011;

    typedef struct packed {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic        alusrc;
        logic        branch;
        logic [3:0]  aluop;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        memtoreg;
        logic [4:0]  rd;
        logic        valid;
        logic        illegal;
    } idex_t;

    function automatic logic [3:0] alu_f3(input logic [2:0] f, input logic alt);
        logic [3:0] op;
        case (f)
            3'b000:  op = alt ? OP_SUB : OP_ADD;
            3'b001:  op = OP_SLL;
            3'b010:  op = OP_SLT;
            3'b011:  op = OP_SLTU;
            3'b100:  op = OP_XOR;
            3'b101:  op = alt ? OP_SRA : OP_SRL;
            3'b110:  op = OP_OR;
            default: op = OP_AND;
        endcase
        return op;
    endfunction

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1_a;
    logic [4:0]  rs2_a;
    logic [4:0]  rd_a;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] rs1_v;
    logic [31:0] rs2_v;
    logic [31:0] rf_q [32];
    logic        legal;
    idex_t       dec;
    idex_t       idex_d;
    idex_t       idex_q;

    assign opc   = instr[6:0];
    assign rd_a  = instr[11:7];
    assign f3    = instr[14:12];
    assign rs1_a = instr[19:15];
    assign rs2_a = instr[24:20];
    assign f7    = instr[31:25];
    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7],
                    instr[30:25], instr[11:8], 1'b0};

    // x0 is hardwired; a same-cycle write-back wins over the stored value
    assign rs1_v = (rs1_a == 5'd0) ? 32'd0 :
                   (wb_en && wb_addr == rs1_a) ? wb_data : rf_q[rs1_a];
    assign rs2_v = (rs2_a == 5'd0) ? 32'd0 :
                   (wb_en && wb_addr == rs2_a) ? wb_data : rf_q[rs2_a];

    always_comb begin
        legal      = 1'b0;
        dec        = '0;
        dec.rs1    = rs1_v;
        dec.rs2    = rs2_v;
        dec.valid  = 1'b1;
        case (opc)
            OPC_R: begin
                if (f7 == 7'b0000000 || f7 == 7'b0100000) begin
                    legal        = 1'b1;
                    dec.regwrite = 1'b1;
                    dec.rd       = rd_a;
                    dec.aluop    = alu_f3(f3, f7[5]);
                end
            end
            OPC_I: begin
                legal        = 1'b1;
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
                dec.rd       = rd_a;
                dec.imm      = imm_i;
                dec.aluop    = alu_f3(f3, f3 == 3'b101 && instr[30]);
            end
            OPC_LW: begin
                if (f3 == 3'b010) begin
                    legal        = 1'b1;
                    dec.regwrite = 1'b1;
                    dec.memread  = 1'b1;
                    dec.memtoreg = 1'b1;
                    dec.alusrc   = 1'b1;
                    dec.rd       = rd_a;
                    dec.imm      = imm_i;
                end
            end
            OPC_SW: begin
                if (f3 == 3'b010) begin
                    legal        = 1'b1;
                    dec.memwrite = 1'b1;
                    dec.alusrc   = 1'b1;
                    dec.imm      = imm_s;
                end
            end
            OPC_BEQ: begin
                if (f3 == 3'b000) begin
                    legal      = 1'b1;
                    dec.branch = 1'b1;
                    dec.aluop  = OP_SUB;
                    dec.imm    = imm_b;
                end
            end
            default: legal = 1'b0;
        endcase
    end

    // A stalled entry is held as-is, but the illegal pulse never repeats
    always_comb begin
        idex_d         = idex_q;
        idex_d.illegal = 1'b0;
        if (flush) begin
            idex_d = '0;
        end else if (!stall) begin
            idex_d = '0;
            if (instr_valid) begin
                if (legal) begin
                    idex_d = dec;
                end else begin
                    idex_d.illegal = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= 32'd0;
            end
        end else if (wb_en && wb_addr != 5'd0) begin
            rf_q[wb_addr] <= wb_data;
        end
    end

    assign rs1_data = idex_q.rs1;
    assign rs2_data = idex_q.rs2;
    assign imm_new  = idex_q.imm;
    assign alusrc   = idex_q.alusrc;
    assign branch   = idex_q.branch;
    assign aluop    = idex_q.aluop;
    assign regwrite = idex_q.regwrite;
    assign memread  = idex_q.memread;
    assign memwrite = idex_q.memwrite;
    assign memtoreg = idex_q.memtoreg;
    assign rd       = idex_q.rd;
    assign ex_valid = idex_q.valid;
    assign illegal  = idex_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: vector table plus stall/flush/reset sequences,
// with expected outputs queued at drive time and checked after the edge.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm_new;
    logic        alusrc;
    logic        branch;
    logic [3:0]  aluop;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
    logic [4:0]  rd;
    logic        ex_valid;
    logic        illegal;

    decode_stage dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .stall(stall), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .imm_new(imm_new), .alusrc(alusrc), .branch(branch), .aluop(aluop),
        .regwrite(regwrite), .memread(memread), .memwrite(memwrite),
        .memtoreg(memtoreg), .rd(rd), .ex_valid(ex_valid), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] imm;
        logic        alusrc;
        logic        branch;
        logic [3:0]  aluop;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        memtoreg;
        logic [4:0]  rd;
        logic        ill;
        logic        use_rs2;
    } ctl_t;

    typedef struct packed {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic        alusrc;
        logic        branch;
        logic [3:0]  aluop;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        memtoreg;
        logic [4:0]  rd;
        logic        ex_valid;
        logic        illegal;
    } out_t;

    typedef struct {
        out_t  o;
        logic  chk_rs2;
        string nm;
    } sb_t;

    typedef struct packed {
        logic [31:0] ins;
        logic        v;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        ctl_t        c;
    } vec_t;

    int          total = 0;
    int          bad = 0;
    logic [31:0] rf [32];
    sb_t         sbq [$];
    out_t        held;
    logic        held_chk;
    vec_t        tbl [20];

    function automatic ctl_t cR(input logic [3:0] op, input logic [4:0] d);
        ctl_t c = '0;
        c.aluop = op; c.rd = d; c.regwrite = 1'b1; c.use_rs2 = 1'b1;
        return c;
    endfunction

    function automatic ctl_t cI(input logic [31:0] im, input logic [3:0] op,
                                input logic [4:0] d);
        ctl_t c = '0;
        c.imm = im; c.aluop = op; c.rd = d; c.regwrite = 1'b1; c.alusrc = 1'b1;
        return c;
    endfunction

    function automatic ctl_t cLW(input logic [31:0] im, input logic [4:0] d);
        ctl_t c = cI(im, 4'b0000, d);
        c.memread = 1'b1; c.memtoreg = 1'b1;
        return c;
    endfunction

    function automatic ctl_t cSW(input logic [31:0] im);
        ctl_t c = '0;
        c.imm = im; c.alusrc = 1'b1; c.memwrite = 1'b1; c.use_rs2 = 1'b1;
        return c;
    endfunction

    function automatic ctl_t cBEQ(input logic [31:0] im);
        ctl_t c = '0;
        c.imm = im; c.branch = 1'b1; c.aluop = 4'b0001; c.use_rs2 = 1'b1;
        return c;
    endfunction

    function automatic ctl_t cILL();
        ctl_t c = '0;
        c.ill = 1'b1;
        return c;
    endfunction

    function automatic logic [31:0] rdm(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wb_en && wb_addr == a) return wb_data;
        return rf[a];
    endfunction

    function automatic out_t actual();
        out_t a;
        a = '{rs1_data, rs2_data, imm_new, alusrc, branch, aluop, regwrite,
              memread, memwrite, memtoreg, rd, ex_valid, illegal};
        return a;
    endfunction

    task automatic check();
        sb_t  e;
        out_t a;
        total++;
        if (sbq.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty: no expected entry at t=%0t", $time);
            return;
        end
        e = sbq.pop_front();
        a = actual();
        if (!e.chk_rs2) begin
            a.rs2   = '0;
            e.o.rs2 = '0;
        end
        if (a !== e.o) begin
            bad++;
            $display("FAIL %s: got %h want %h", e.nm, a, e.o);
        end
    endtask

    task automatic step(input logic [31:0] ins, input logic v, input logic st,
                        input logic fl, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input ctl_t c, input string nm);
        sb_t e;
        instr = ins; instr_valid = v; stall = st; flush = fl;
        wb_en = we; wb_addr = wa; wb_data = wd;
        e.o = '0;
        e.chk_rs2 = 1'b1;
        e.nm = nm;
        if (fl) begin
            e.o = '0;
        end else if (st) begin
            e.o = held;
            e.o.illegal = 1'b0;
            e.chk_rs2 = held_chk;
        end else if (!v) begin
            e.o = '0;
        end else if (c.ill) begin
            e.o.illegal = 1'b1;
        end else begin
            e.o.rs1 = rdm(ins[19:15]);
            e.o.rs2 = c.use_rs2 ? rdm(ins[24:20]) : 32'd0;
            e.o.imm = c.imm;
            e.o.alusrc = c.alusrc;
            e.o.branch = c.branch;
            e.o.aluop = c.aluop;
            e.o.regwrite = c.regwrite;
            e.o.memread = c.memread;
            e.o.memwrite = c.memwrite;
            e.o.memtoreg = c.memtoreg;
            e.o.rd = c.rd;
            e.o.ex_valid = 1'b1;
            e.chk_rs2 = c.use_rs2;
        end
        sbq.push_back(e);
        held = e.o;
        held_chk = e.chk_rs2;
        @(posedge clk);
        if (we && wa != 5'd0) rf[wa] = wd;
        #1;
        check();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        sb_t r;
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        held = '0;
        held_chk = 1'b1;

        tbl[0]  = '{32'h0, 1'b0, 1'b1, 5'd1, 32'h5, '0};
        tbl[1]  = '{32'h0, 1'b0, 1'b1, 5'd2, 32'hFFFFFFFB, '0};
        tbl[2]  = '{32'h402081B3, 1'b1, 1'b0, 5'd0, 32'h0, cR(4'b0001, 5'd3)};
        tbl[3]  = '{32'hFFC0A203, 1'b1, 1'b0, 5'd0, 32'h0, cLW(32'hFFFFFFFC, 5'd4)};
        tbl[4]  = '{32'hFE208CE3, 1'b1, 1'b0, 5'd0, 32'h0, cBEQ(32'hFFFFFFF8)};
        tbl[5]  = '{32'h0020F333, 1'b1, 1'b0, 5'd0, 32'h0, cR(4'b0010, 5'd6)};
        tbl[6]  = '{32'h4020D3B3, 1'b1, 1'b0, 5'd0, 32'h0, cR(4'b0111, 5'd7)};
        tbl[7]  = '{32'h0020B433, 1'b1, 1'b0, 5'd0, 32'h0, cR(4'b1001, 5'd8)};
        tbl[8]  = '{32'h4030D493, 1'b1, 1'b0, 5'd0, 32'h0, cI(32'h403, 4'b0111, 5'd9)};
        tbl[9]  = '{32'hFFF12513, 1'b1, 1'b0, 5'd0, 32'h0,
                    cI(32'hFFFFFFFF, 4'b1000, 5'd10)};
        tbl[10] = '{32'h0020A423, 1'b1, 1'b0, 5'd0, 32'h0, cSW(32'h8)};
        tbl[11] = '{32'h0000007F, 1'b1, 1'b0, 5'd0, 32'h0, cILL()};
        tbl[12] = '{32'h0020F333, 1'b1, 1'b0, 5'd0, 32'h0, cR(4'b0010, 5'd6)};
        tbl[13] = '{32'hFE209CE3, 1'b1, 1'b0, 5'd0, 32'h0, cILL()};
        tbl[14] = '{32'h022081B3, 1'b1, 1'b0, 5'd0, 32'h0, cILL()};
        tbl[15] = '{32'hFFC08203, 1'b1, 1'b0, 5'd0, 32'h0, cILL()};
        tbl[16] = '{32'h00108293, 1'b1, 1'b1, 5'd1, 32'h12345678,
                    cI(32'h1, 4'b0000, 5'd5)};
        tbl[17] = '{32'h000005B3, 1'b1, 1'b1, 5'd0, 32'hDEAD, cR(4'b0000, 5'd11)};
        tbl[18] = '{32'h000005B3, 1'b1, 1'b0, 5'd0, 32'h0, cR(4'b0000, 5'd11)};
        tbl[19] = '{32'h402081B3, 1'b0, 1'b0, 5'd0, 32'h0, cR(4'b0001, 5'd3)};

        #1;
        r.o = '0; r.chk_rs2 = 1'b1; r.nm = "reset_state";
        sbq.push_back(r);
        check();
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            step(tbl[i].ins, tbl[i].v, 1'b0, 1'b0, tbl[i].we, tbl[i].wa,
                 tbl[i].wd, tbl[i].c, $sformatf("vec%0d", i));
        end

        step(32'h402081B3, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,
             cR(4'b0001, 5'd3), "pre_stall");
        step(32'h00108293, 1'b1, 1'b1, 1'b0, 1'b1, 5'd1, 32'h99,
             cI(32'h1, 4'b0000, 5'd5), "stall1");
        step(32'h00108293, 1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 32'h55,
             cI(32'h1, 4'b0000, 5'd5), "stall2");
        step(32'h00108293, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0,
             cI(32'h1, 4'b0000, 5'd5), "stall_flush");

        step(32'h0000007F, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, cILL(), "ill_pre");
        step(32'h402081B3, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,
             cR(4'b0001, 5'd3), "ill_stall");

        step(32'hFFC0A203, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,
             cLW(32'hFFFFFFFC, 5'd4), "pre_reset");
        instr_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        r.o = '0; r.chk_rs2 = 1'b1; r.nm = "async_reset";
        sbq.push_back(r);
        check();
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        held = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(32'h00528633, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,
             cR(4'b0000, 5'd12), "after_reset_x5");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction-decode and register-file stage that drives the execute stage's operand and control inputs. It decodes one RV32I instruction per cycle, reads two source registers from an internal 32x32 register file, builds the sign-extended immediate and ALU control, and presents the results through an ID/EX pipeline register. The same register file takes write-back results from the end of the datapath.

## Interface
Parameters:
- none (XLEN fixed at 32, 32 architectural registers)

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- instr  in  32  instruction word to decode.
- instr_valid  in  1  `instr` is a real instruction; when low, a bubble is captured.
- stall  in  1  holds the ID/EX register and blocks capture of the current instruction.
- flush  in  1  loads a bubble into the ID/EX register; takes priority over `stall`.
- wb_en  in  1  register-file write enable.
- wb_addr  in  5  write-back destination register.
- wb_data  in  32  write-back data.
- rs1_data  out  32  source-1 operand.
- rs2_data  out  32  source-2 operand.
- imm_new  out  32  sign-extended immediate.
- alusrc  out  1  1 selects `imm_new` as ALU input 2; 0 selects `rs2_data`.
- branch  out  1  instruction is BEQ.
- aluop  out  4  ALU operation.
- regwrite, memread, memwrite, memtoreg  out  1 each  downstream control signals.
- rd  out  5  destination register.
- ex_valid  out  1  ID/EX register holds a valid instruction.
- illegal  out  1  captured instruction had an unsupported encoding; pulses for one cycle.

## Operation
- aluop encoding:
  - ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100
  - SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001
- Supported opcodes:
  - R 0110011: all funct3 values. funct7[5] selects SUB (f3=000) and SRA (f3=101). regwrite=1, alusrc=0, imm=0.
  - I-ALU 0010011: ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI. instr[30] selects SRAI. regwrite=1, alusrc=1.
  - LW 0000011 (f3=010): ADD, alusrc=1, regwrite=1, memread=1, memtoreg=1.
  - SW 0100011 (f3=010): ADD, alusrc=1, memwrite=1, rd=0.
  - BEQ 1100011 (f3=000): SUB, alusrc=0, branch=1, rd=0.
- Immediates, all sign-extended from instr[31]:
  - I: instr[31:20]
  - S: {instr[31:25],instr[11:7]}
  - B: {instr[31],instr[7],instr[30:25],instr[11:8],1'b0}
- Any other opcode/funct3 combination, or R-type with funct7 other than 0000000 or 0100000, is illegal. An illegal instruction is captured as a bubble: all control outputs 0, ex_valid=0, illegal=1.
- Register file:
  - x0 reads as 0 always; writes to x0 are ignored.
  - Writes occur on the rising clock edge when wb_en=1.
  - Write-first bypass: if wb_en=1 and wb_addr equals a nonzero rs field in the same cycle, the captured operand is wb_data.
- The ID/EX register on each edge:
  - flush=1: captures a bubble.
  - else stall=1: holds all values; illegal goes to 0.
  - else instr_valid=0: captures a bubble.
  - else: captures the decoded instruction.
- Register-file writes proceed regardless of stall or flush.

## Timing
- Decode latency is 1 cycle: instruction presented at edge N appears on the outputs after edge N.
- Write-back written at edge N is visible both to an instruction decoded in the same cycle (bypass) and to all later reads.
- Reset (asynchronous, immediate): all outputs 0, ex_valid=0, illegal=0, all 32 registers 0.
- Reset deasserting mid-stream: the first capture happens on the first rising edge with rst=0.
- Bubble value: every output is 0.
- A held (stalled) entry keeps its operand values even if the source register is rewritten during the stall. Operands are not re-read.

## Test plan
- Reset: assert rst mid-cycle with a valid instruction loaded -> all outputs go to 0 without a clock edge; a subsequent read of x5 returns 0.
- Write then decode: write x1=0x00000005 and x2=0xFFFFFFFB, then decode `sub x3,x1,x2` (0x402081B3) -> rs1_data=5, rs2_data=0xFFFFFFFB, aluop=0001, alusrc=0, regwrite=1, rd=3, ex_valid=1.
- Immediates:
  - `lw x4,-4(x1)` (0xFFC0A203) -> imm_new=0xFFFFFFFC, memread=1, memtoreg=1, aluop=0000.
  - `beq x1,x2,-8` (0xFE208CE3) -> imm_new=0xFFFFFFF8, branch=1, aluop=0001.
- Bypass and x0:
  - wb_en=1, wb_addr=1, wb_data=0x12345678 in the same cycle as decoding `addi x5,x1,1` (0x00108293) -> rs1_data=0x12345678, imm_new=1.
  - Write 0xDEAD to x0, then read x0 -> 0.
- Stall/flush: stall for 2 cycles with a new instruction on `instr` -> outputs unchanged. Then assert stall and flush together -> bubble, ex_valid=0.
- Illegal: opcode 0x7F, or BEQ encoding with f3=001 -> illegal=1 for one cycle, all control outputs 0; the next valid instruction clears illegal.
